// File: rtl/vsc_shift_count_if.sv
`default_nettype none
// ============================================================================
// Module   : vsc_shift_count_if
// Purpose  : Pixel shifter, delay-line and line-counter signal bundle.
// Revision : 1.0
// ============================================================================
interface vsc_shift_count_if #(
    parameter int PLANES = 3,
    parameter int DEPTH  = 4,
    parameter int DCH    = 2,
    parameter int VBITS  = 8
);
    logic                      SHIFT_EN;
    logic [PLANES-1:0]         SHIFT_IN;
    logic                      GRAB;
    logic                      REV_A;
    logic                      REV_B;
    logic [DCH-1:0]            DLY_IN;
    logic [DCH-1:0]            DLY_OUT;
    logic [PLANES*DEPTH-1:0]   PIX_OUT;
    logic                      VCLK_EN;
    logic [VBITS-1:0]          VSTART;
    logic [VBITS-1:0]          VEND;
    logic                      VFLIP;
    logic [VBITS-1:0]          VCOUNT;
    logic                      VWRAP;
    logic                      FIELD;

    modport master (
        output SHIFT_EN, SHIFT_IN, GRAB, REV_A, REV_B, DLY_IN,
        output VCLK_EN, VSTART, VEND, VFLIP,
        input  DLY_OUT, PIX_OUT, VCOUNT, VWRAP, FIELD
    );

    modport slave (
        input  SHIFT_EN, SHIFT_IN, GRAB, REV_A, REV_B, DLY_IN,
        input  VCLK_EN, VSTART, VEND, VFLIP,
        output DLY_OUT, PIX_OUT, VCOUNT, VWRAP, FIELD
    );
endinterface
`default_nettype wire

// File: rtl/vsc_shift_count.sv
`default_nettype none
// ============================================================================
// Module   : vsc_shift_count
// Purpose  : N-plane serial-to-parallel shifter with grab, delay lines, and
//            programmable vertical line counter with field toggle.
// Revision : 1.0
// ============================================================================
module vsc_shift_count #(
    parameter int PLANES = 3,
    parameter int DEPTH  = 4,
    parameter int DCH    = 2,
    parameter int DLEN   = 8,
    parameter int VBITS  = 8,
    parameter int VRESET = 8
) (
    input  wire logic       CLK,
    input  wire logic       nRESET,
    vsc_shift_count_if.slave bus
);
    localparam logic [VBITS-1:0] c_VRESET = VBITS'(VRESET);

    logic w_sel;
    assign w_sel = bus.REV_A ^ bus.REV_B;

    // ------------------------------------------------------------------
    // Per-plane shift and holding registers
    // ------------------------------------------------------------------
    for (genvar p = 0; p < PLANES; p++) begin : g_plane
        logic [DEPTH-1:0] r_sr;
        logic [DEPTH-1:0] r_hold;
        logic [DEPTH-1:0] w_rev;

        if (DEPTH == 1) begin : g_d1
            always_ff @(posedge CLK or negedge nRESET) begin
                if (!nRESET)          r_sr <= '0;
                else if (bus.SHIFT_EN) r_sr <= bus.SHIFT_IN[p];
            end
        end else begin : g_dn
            always_ff @(posedge CLK or negedge nRESET) begin
                if (!nRESET)          r_sr <= '0;
                else if (bus.SHIFT_EN) r_sr <= {r_sr[DEPTH-2:0], bus.SHIFT_IN[p]};
            end
        end

        // Grab samples the pre-shift value when it coincides with a strobe.
        always_ff @(posedge CLK or negedge nRESET) begin
            if (!nRESET)      r_hold <= '0;
            else if (bus.GRAB) r_hold <= r_sr;
        end

        always_comb begin
            w_rev = '0;
            for (int i = 0; i < DEPTH; i++) begin
                w_rev[i] = r_hold[DEPTH-1-i];
            end
        end

        assign bus.PIX_OUT[p*DEPTH +: DEPTH] = w_sel ? r_hold : w_rev;
    end

    // ------------------------------------------------------------------
    // Delay-line channels: DLEN stages plus an output register
    // ------------------------------------------------------------------
    for (genvar c = 0; c < DCH; c++) begin : g_dch
        logic [DLEN-1:0] r_stg;
        logic            r_out;

        if (DLEN == 1) begin : g_l1
            always_ff @(posedge CLK or negedge nRESET) begin
                if (!nRESET)           r_stg <= '0;
                else if (bus.SHIFT_EN) r_stg <= bus.DLY_IN[c];
            end
        end else begin : g_ln
            always_ff @(posedge CLK or negedge nRESET) begin
                if (!nRESET)           r_stg <= '0;
                else if (bus.SHIFT_EN) r_stg <= {r_stg[DLEN-2:0], bus.DLY_IN[c]};
            end
        end

        always_ff @(posedge CLK or negedge nRESET) begin
            if (!nRESET)           r_out <= 1'b0;
            else if (bus.SHIFT_EN) r_out <= r_stg[DLEN-1];
        end

        assign bus.DLY_OUT[c] = r_out;
    end

    // ------------------------------------------------------------------
    // Vertical line counter
    // ------------------------------------------------------------------
    logic [VBITS-1:0] r_cnt;
    logic             r_vwrap;
    logic             r_field;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_cnt   <= c_VRESET;
            r_vwrap <= 1'b0;
            r_field <= 1'b0;
        end else if (bus.VCLK_EN) begin
            if (r_cnt == bus.VEND) begin
                r_cnt   <= bus.VSTART;
                r_vwrap <= 1'b1;
                r_field <= ~r_field;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_vwrap <= 1'b0;
            end
        end else begin
            r_vwrap <= 1'b0;
        end
    end

    // Flip is presentation only; compare and reload use the raw count.
    assign bus.VCOUNT = r_cnt ^ {VBITS{bus.VFLIP}};
    assign bus.VWRAP  = r_vwrap;
    assign bus.FIELD  = r_field;

endmodule
`default_nettype wire

// File: tb/tb_vsc_shift_count.sv
`default_nettype none
// ============================================================================
// Module   : tb_vsc_shift_count
// Purpose  : Directed, table-driven self-checking bench for vsc_shift_count.
// Revision : 1.0
// ============================================================================
module tb_vsc_shift_count;
    logic CLK    = 1'b0;
    logic nRESET = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    always #5 CLK = ~CLK;

    vsc_shift_count_if #(.PLANES(3), .DEPTH(4), .DCH(2), .VBITS(8)) bus ();

    vsc_shift_count #(
        .PLANES(3), .DEPTH(4), .DCH(2), .DLEN(8), .VBITS(8), .VRESET(8)
    ) u_dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    typedef struct {
        logic        shen;
        logic [2:0]  sin;
        logic        grab;
        logic        reva;
        logic        revb;
        logic [11:0] exp_pix;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic dstrobe(input logic [1:0] din);
        bus.DLY_IN   = din;
        bus.SHIFT_EN = 1'b1;
        tick();
        bus.SHIFT_EN = 1'b0;
        bus.DLY_IN   = 2'b00;
    endtask

    initial begin
        // {shen, sin(p2,p1,p0), grab, rev_a, rev_b, expected PIX_OUT}
        tbl[0]  = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[1]  = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[2]  = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[3]  = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 12'h000};
        tbl[4]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 12'hF8D};
        tbl[5]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 12'hF1B};
        tbl[6]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 12'hF8D};
        tbl[7]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 12'hF1B};
        tbl[8]  = '{1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 12'hF8D};
        tbl[9]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 12'h7C6};
        tbl[10] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 12'hE36};

        bus.SHIFT_EN = 1'b0; bus.SHIFT_IN = '0; bus.GRAB = 1'b0;
        bus.REV_A = 1'b0; bus.REV_B = 1'b0; bus.DLY_IN = '0;
        bus.VCLK_EN = 1'b0; bus.VSTART = '0; bus.VEND = '0; bus.VFLIP = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_vcount_in_reset", 32'(bus.VCOUNT), 32'h08);
        nRESET = 1'b1;
        tick();
        chk("rst_vcount", 32'(bus.VCOUNT), 32'h08);
        chk("rst_pix",    32'(bus.PIX_OUT), 32'h0);
        chk("rst_dly",    32'(bus.DLY_OUT), 32'h0);
        chk("rst_field",  32'(bus.FIELD), 32'h0);
        chk("rst_vwrap",  32'(bus.VWRAP), 32'h0);
        bus.VFLIP = 1'b1;
        #1;
        chk("rst_vflip", 32'(bus.VCOUNT), 32'hF7);
        bus.VFLIP = 1'b0;
        #1;

        // Shifter / grab / reverse table
        for (int v = 0; v < 11; v++) begin
            bus.SHIFT_EN = tbl[v].shen;
            bus.SHIFT_IN = tbl[v].sin;
            bus.GRAB     = tbl[v].grab;
            bus.REV_A    = tbl[v].reva;
            bus.REV_B    = tbl[v].revb;
            tick();
            chk($sformatf("pix_vec%0d", v), 32'(bus.PIX_OUT), 32'(tbl[v].exp_pix));
        end
        bus.SHIFT_EN = 1'b0; bus.SHIFT_IN = '0; bus.GRAB = 1'b0;
        bus.REV_A = 1'b0; bus.REV_B = 1'b0;

        // Delay line: single pulse, contiguous strobes
        for (int n = 1; n <= 12; n++) begin
            dstrobe((n == 1) ? 2'b01 : 2'b00);
            chk($sformatf("dly_strobe%0d", n), 32'(bus.DLY_OUT), (n == 9) ? 32'h1 : 32'h0);
        end

        // Delay line: pulse with three idle clocks after the 4th strobe
        for (int n = 1; n <= 12; n++) begin
            dstrobe((n == 1) ? 2'b01 : 2'b00);
            chk($sformatf("dlygap_strobe%0d", n), 32'(bus.DLY_OUT), (n == 9) ? 32'h1 : 32'h0);
            if (n == 4) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    chk("dlygap_idle", 32'(bus.DLY_OUT), 32'h0);
                end
            end
        end

        // Counter wrap through natural overflow
        chk("cnt_start", 32'(bus.VCOUNT), 32'h08);
        bus.VSTART  = 8'hF8;
        bus.VEND    = 8'h07;
        bus.VCLK_EN = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            chk("cnt_seq",   32'(bus.VCOUNT), (k == 256) ? 32'hF8 : 32'((8 + k) % 256));
            chk("cnt_vwrap", 32'(bus.VWRAP),  (k == 256) ? 32'h1  : 32'h0);
            chk("cnt_field", 32'(bus.FIELD),  (k == 256) ? 32'h1  : 32'h0);
        end
        bus.VCLK_EN = 1'b0;
        tick();
        chk("cnt_idle_vwrap", 32'(bus.VWRAP),  32'h0);
        chk("cnt_idle_hold",  32'(bus.VCOUNT), 32'hF8);

        // Run to 0x42 with FIELD=1, and load the delay lines with ones
        bus.VEND    = 8'h80;
        bus.VCLK_EN = 1'b1;
        repeat (74) tick();
        bus.VCLK_EN = 1'b0;
        chk("mid_count", 32'(bus.VCOUNT), 32'h42);
        chk("mid_field", 32'(bus.FIELD),  32'h1);
        for (int n = 0; n < 9; n++) dstrobe(2'b11);
        chk("mid_dly", 32'(bus.DLY_OUT), 32'h3);

        // Asynchronous reset between edges
        #2;
        nRESET = 1'b0;
        #1;
        chk("arst_vcount", 32'(bus.VCOUNT),  32'h08);
        chk("arst_field",  32'(bus.FIELD),   32'h0);
        chk("arst_dly",    32'(bus.DLY_OUT), 32'h0);
        chk("arst_pix",    32'(bus.PIX_OUT), 32'h0);
        @(negedge CLK);
        nRESET = 1'b1;
        bus.VCLK_EN = 1'b1;
        tick();
        bus.VCLK_EN = 1'b0;
        chk("arst_first_count", 32'(bus.VCOUNT), 32'h09);
        chk("arst_first_vwrap", 32'(bus.VWRAP),  32'h0);
        dstrobe(2'b00);
        chk("arst_dly_flushed", 32'(bus.DLY_OUT), 32'h0);

        // VSTART == VEND reloads on every strobe
        bus.VSTART  = 8'h09;
        bus.VEND    = 8'h09;
        bus.VCLK_EN = 1'b1;
        tick();
        chk("eq_count1", 32'(bus.VCOUNT), 32'h09);
        chk("eq_vwrap1", 32'(bus.VWRAP),  32'h1);
        chk("eq_field1", 32'(bus.FIELD),  32'h1);
        tick();
        chk("eq_vwrap2", 32'(bus.VWRAP),  32'h1);
        chk("eq_field2", 32'(bus.FIELD),  32'h0);
        bus.VCLK_EN = 1'b0;
        bus.VFLIP   = 1'b1;
        tick();
        chk("flip_count", 32'(bus.VCOUNT), 32'hF6);
        chk("flip_vwrap", 32'(bus.VWRAP),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
